// File: rtl/axis_rr_arbiter.sv
// N-to-1 AXI4-Stream round-robin arbiter with packet-granular grants.
// Optional per-packet beat watchdog is enabled by defining ARB_WATCHDOG_EN.
module axis_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int DATA_W      = 8,
    parameter int DEST_W      = 5,
    parameter int MAX_BEATS   = 16
) (
    input  logic                          i_sclk,
    input  logic                          i_srst,
    input  logic [NUM_MASTERS-1:0]        i_m_tvalid,
    input  logic [NUM_MASTERS*DATA_W-1:0] i_m_tdata,
    input  logic [NUM_MASTERS*DEST_W-1:0] i_m_tdest,
    input  logic [NUM_MASTERS-1:0]        i_m_tlast,
    output logic [NUM_MASTERS-1:0]        o_m_tready,
    output logic                          o_s_tvalid,
    output logic [DATA_W-1:0]             o_s_tdata,
    output logic [DEST_W-1:0]             o_s_tdest,
    output logic                          o_s_tlast,
    input  logic                          i_s_tready,
    output logic [NUM_MASTERS-1:0]        o_grant,
    output logic                          o_busy,
    output logic                          o_wd_err
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || MAX_BEATS < 1) begin : g_param_check
        $error("axis_rr_arbiter: unsupported NUM_MASTERS or MAX_BEATS");
    end

    state_t                   state_q, state_d;
    logic [NUM_MASTERS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]         gidx_q, gidx_d;
    logic [IDX_W-1:0]         last_q, last_d;
    logic [IDX_W-1:0]         pick_s;
    logic                     pick_vld_s;
    logic                     busy_s;
    logic                     sel_tvalid_s;
    logic                     sel_tlast_s;
    logic [DATA_W-1:0]        sel_tdata_s;
    logic [DEST_W-1:0]        sel_tdest_s;
    logic                     xfer_s;
    logic                     wd_hit_s;

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Rotating-priority search starting just after the last granted master
    always_comb begin
        pick_s     = last_q;
        pick_vld_s = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            int               cand;
            logic [IDX_W-1:0] cand_idx;
            logic             hit;
            cand       = int'(last_q) + i;
            cand       = (cand >= NUM_MASTERS) ? (cand - NUM_MASTERS) : cand;
            cand_idx   = IDX_W'(cand);
            hit        = !pick_vld_s && i_m_tvalid[cand_idx];
            pick_s     = hit ? cand_idx : pick_s;
            pick_vld_s = pick_vld_s | hit;
        end
    end

    assign busy_s       = (state_q == ST_LOCKED);
    assign sel_tvalid_s = i_m_tvalid[gidx_q];
    assign sel_tlast_s  = i_m_tlast[gidx_q];
    assign sel_tdata_s  = i_m_tdata[gidx_q*DATA_W +: DATA_W];
    assign sel_tdest_s  = i_m_tdest[gidx_q*DEST_W +: DEST_W];
    assign xfer_s       = busy_s && sel_tvalid_s && i_s_tready;

    // Downstream mux; tready only reaches the granted master, everything is 0 when idle
    always_comb begin
        o_s_tvalid = 1'b0;
        o_s_tdata  = {DATA_W{1'b0}};
        o_s_tdest  = {DEST_W{1'b0}};
        o_s_tlast  = 1'b0;
        o_m_tready = {NUM_MASTERS{1'b0}};
        if (busy_s) begin
            o_s_tvalid = sel_tvalid_s;
            o_s_tdata  = sel_tdata_s;
            o_s_tdest  = sel_tdest_s;
            o_s_tlast  = sel_tlast_s;
            o_m_tready = grant_q & {NUM_MASTERS{i_s_tready}};
        end else begin
            o_m_tready = {NUM_MASTERS{1'b0}};
        end
    end

    // Arbitration FSM next state: grant taken in IDLE, released by tlast or watchdog
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    state_d = ST_LOCKED;
                    gidx_d  = pick_s;
                    grant_d = onehot(pick_s);
                end else begin
                    grant_d = {NUM_MASTERS{1'b0}};
                end
            end
            ST_LOCKED: begin
                if ((xfer_s && sel_tlast_s) || wd_hit_s) begin
                    state_d = ST_IDLE;
                    grant_d = {NUM_MASTERS{1'b0}};
                    last_d  = gidx_q;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = {NUM_MASTERS{1'b0}};
            end
        endcase
    end

    // FSM and grant registers; reset points the pointer so master 0 wins first
    always_ff @(posedge i_sclk or posedge i_srst) begin
        if (i_srst) begin
            state_q <= ST_IDLE;
            grant_q <= {NUM_MASTERS{1'b0}};
            gidx_q  <= {IDX_W{1'b0}};
            last_q  <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
        end
    end

    assign o_grant = grant_q;
    assign o_busy  = busy_s;

`ifdef ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(MAX_BEATS) + 1;

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             wd_err_q;

    // Beat counter: cleared while idle, counts accepted non-last beats
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (!busy_s) begin
            beat_cnt_d = {CNT_W{1'b0}};
        end else if (xfer_s && !sel_tlast_s) begin
            beat_cnt_d = beat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
    end

    // Abort fires on the beat that brings the count to the limit without tlast
    assign wd_hit_s = busy_s && xfer_s && !sel_tlast_s && (beat_cnt_d == CNT_W'(MAX_BEATS));

    // Watchdog counter and one-cycle error pulse
    always_ff @(posedge i_sclk or posedge i_srst) begin
        if (i_srst) begin
            beat_cnt_q <= {CNT_W{1'b0}};
            wd_err_q   <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            wd_err_q   <= wd_hit_s;
        end
    end

    assign o_wd_err = wd_err_q;
`else
    assign wd_hit_s = 1'b0;
    assign o_wd_err = 1'b0;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed, table-driven bench for axis_rr_arbiter (4 masters, 8-bit data).
module tb_axis_rr_arbiter;

    localparam int NM = 4;
    localparam int DW = 8;
    localparam int TW = 5;

    logic              clk = 1'b0;
    logic              srst;
    logic [NM-1:0]     m_tvalid;
    logic [NM*DW-1:0]  m_tdata;
    logic [NM*TW-1:0]  m_tdest;
    logic [NM-1:0]     m_tlast;
    logic [NM-1:0]     m_tready;
    logic              s_tvalid;
    logic [DW-1:0]     s_tdata;
    logic [TW-1:0]     s_tdest;
    logic              s_tlast;
    logic              s_tready;
    logic [NM-1:0]     grant;
    logic              busy;
    logic              wd_err;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic          rst;
        logic [3:0]    vld;
        logic [3:0]    lst;
        logic [7:0]    base;
        logic          rdy;
        logic [3:0]    e_grant;
        logic          e_busy;
        logic          e_sv;
        logic [7:0]    e_sd;
        logic [4:0]    e_dest;
        logic          e_sl;
        logic [3:0]    e_mrdy;
    } vec_t;

    vec_t tbl[$];

    axis_rr_arbiter #(
        .NUM_MASTERS(NM), .DATA_W(DW), .DEST_W(TW), .MAX_BEATS(16)
    ) dut (
        .i_sclk(clk), .i_srst(srst),
        .i_m_tvalid(m_tvalid), .i_m_tdata(m_tdata), .i_m_tdest(m_tdest),
        .i_m_tlast(m_tlast), .o_m_tready(m_tready),
        .o_s_tvalid(s_tvalid), .o_s_tdata(s_tdata), .o_s_tdest(s_tdest),
        .o_s_tlast(s_tlast), .i_s_tready(s_tready),
        .o_grant(grant), .o_busy(busy), .o_wd_err(wd_err)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic [3:0] vld, input logic [3:0] lst,
                       input logic [7:0] base, input logic rdy, input logic [3:0] g,
                       input logic b, input logic sv, input logic [7:0] sd,
                       input logic [4:0] dst, input logic sl, input logic [3:0] mr);
        vec_t v;
        v.rst = rst; v.vld = vld; v.lst = lst; v.base = base; v.rdy = rdy;
        v.e_grant = g; v.e_busy = b; v.e_sv = sv; v.e_sd = sd; v.e_dest = dst;
        v.e_sl = sl; v.e_mrdy = mr;
        tbl.push_back(v);
    endtask

    // Idle row: every output must be zero
    task automatic add_idle(input logic rst, input logic [3:0] vld, input logic [3:0] lst,
                            input logic [7:0] base, input logic rdy);
        add(rst, vld, lst, base, rdy, 4'b0000, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 4'b0000);
    endtask

    // Master k carries data base + 16*k and tdest k
    task automatic drive(input logic [3:0] vld, input logic [3:0] lst,
                         input logic [7:0] base, input logic rdy);
        m_tvalid = vld;
        m_tlast  = lst;
        s_tready = rdy;
        for (int k = 0; k < NM; k++) begin
            m_tdata[k*DW +: DW] = base + 8'(k * 16);
            m_tdest[k*TW +: TW] = 5'(k);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        srst = 1'b1;
        drive(4'b0000, 4'b0000, 8'h00, 1'b1);

        // Master 2 alone, 3-beat packet A1..A3 to tdest 2
        add_idle(0, 4'b0000, 4'b0000, 8'h00, 1);
        add_idle(0, 4'b0100, 4'b0000, 8'h81, 1);
        add(0, 4'b0100, 4'b0000, 8'h81, 1, 4'b0100, 1, 1, 8'hA1, 5'd2, 0, 4'b0100);
        add(0, 4'b0100, 4'b0000, 8'h82, 1, 4'b0100, 1, 1, 8'hA2, 5'd2, 0, 4'b0100);
        add(0, 4'b0100, 4'b0100, 8'h83, 1, 4'b0100, 1, 1, 8'hA3, 5'd2, 1, 4'b0100);
        add_idle(0, 4'b0000, 4'b0000, 8'h00, 1);
        // Reset, then all masters stream single-beat packets
        add_idle(1, 4'b1111, 4'b1111, 8'h00, 1);
        add_idle(0, 4'b1111, 4'b1111, 8'h00, 1);
        add(0, 4'b1111, 4'b1111, 8'h00, 1, 4'b0001, 1, 1, 8'h00, 5'd0, 1, 4'b0001);
        add_idle(0, 4'b1111, 4'b1111, 8'h00, 1);
        add(0, 4'b1111, 4'b1111, 8'h00, 1, 4'b0010, 1, 1, 8'h10, 5'd1, 1, 4'b0010);
        add_idle(0, 4'b1111, 4'b1111, 8'h00, 1);
        add(0, 4'b1111, 4'b1111, 8'h00, 1, 4'b0100, 1, 1, 8'h20, 5'd2, 1, 4'b0100);
        add_idle(0, 4'b1111, 4'b1111, 8'h00, 1);
        add(0, 4'b1111, 4'b1111, 8'h00, 1, 4'b1000, 1, 1, 8'h30, 5'd3, 1, 4'b1000);
        add_idle(0, 4'b1111, 4'b1111, 8'h00, 1);
        add(0, 4'b1111, 4'b1111, 8'h00, 1, 4'b0001, 1, 1, 8'h00, 5'd0, 1, 4'b0001);
        // Master 1 4-beat packet under toggling backpressure, master 0 waiting
        add_idle(0, 4'b0011, 4'b0000, 8'h40, 1);
        add(0, 4'b0011, 4'b0000, 8'h40, 1, 4'b0010, 1, 1, 8'h50, 5'd1, 0, 4'b0010);
        add(0, 4'b0011, 4'b0000, 8'h41, 0, 4'b0010, 1, 1, 8'h51, 5'd1, 0, 4'b0000);
        add(0, 4'b0011, 4'b0000, 8'h41, 1, 4'b0010, 1, 1, 8'h51, 5'd1, 0, 4'b0010);
        add(0, 4'b0011, 4'b0000, 8'h42, 0, 4'b0010, 1, 1, 8'h52, 5'd1, 0, 4'b0000);
        add(0, 4'b0011, 4'b0000, 8'h42, 1, 4'b0010, 1, 1, 8'h52, 5'd1, 0, 4'b0010);
        add(0, 4'b0011, 4'b0010, 8'h43, 0, 4'b0010, 1, 1, 8'h53, 5'd1, 1, 4'b0000);
        add(0, 4'b0011, 4'b0010, 8'h43, 1, 4'b0010, 1, 1, 8'h53, 5'd1, 1, 4'b0010);
        add_idle(0, 4'b0001, 4'b0001, 8'h40, 1);
        add(0, 4'b0001, 4'b0001, 8'h40, 1, 4'b0001, 1, 1, 8'h40, 5'd0, 1, 4'b0001);
        // Master 3 drops tvalid for 5 cycles mid-packet while master 0 requests
        add_idle(0, 4'b1000, 4'b0000, 8'h00, 1);
        add(0, 4'b1000, 4'b0000, 8'h00, 1, 4'b1000, 1, 1, 8'h30, 5'd3, 0, 4'b1000);
        for (int i = 0; i < 5; i++)
            add(0, 4'b0001, 4'b0000, 8'h00, 1, 4'b1000, 1, 0, 8'h30, 5'd3, 0, 4'b1000);
        add(0, 4'b1001, 4'b1001, 8'h01, 1, 4'b1000, 1, 1, 8'h31, 5'd3, 1, 4'b1000);
        add_idle(0, 4'b0001, 4'b0001, 8'h01, 1);
        add(0, 4'b0001, 4'b0001, 8'h01, 1, 4'b0001, 1, 1, 8'h01, 5'd0, 1, 4'b0001);
        // Reset during beat 2 of a master 1 packet; pointer returns to master 0 first
        add_idle(0, 4'b0010, 4'b0000, 8'h60, 1);
        add(0, 4'b0010, 4'b0000, 8'h60, 1, 4'b0010, 1, 1, 8'h70, 5'd1, 0, 4'b0010);
        add_idle(1, 4'b0011, 4'b0000, 8'h61, 1);
        add_idle(0, 4'b0011, 4'b0011, 8'h61, 1);
        add(0, 4'b0011, 4'b0011, 8'h61, 1, 4'b0001, 1, 1, 8'h61, 5'd0, 1, 4'b0001);

        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[r]) begin
            srst = tbl[r].rst;
            drive(tbl[r].vld, tbl[r].lst, tbl[r].base, tbl[r].rdy);
            #2;
            check($sformatf("row%0d", r),
                  {7'd0, grant, busy, s_tvalid, s_tdata, s_tdest, s_tlast, m_tready, wd_err},
                  {7'd0, tbl[r].e_grant, tbl[r].e_busy, tbl[r].e_sv, tbl[r].e_sd,
                   tbl[r].e_dest, tbl[r].e_sl, tbl[r].e_mrdy, 1'b0});
            @(posedge clk);
            #1;
        end

`ifdef ARB_WATCHDOG_EN
        // Master 0 streams without tlast; master 1 waits
        begin
            int beats = 0;
            int beats_at_pulse = -1;
            int pulses = 0;
            logic [3:0] next_g = 4'b0000;
            srst = 1'b1;
            drive(4'b0011, 4'b0000, 8'h00, 1'b1);
            @(posedge clk);
            #1;
            srst = 1'b0;
            for (int c = 0; c < 60 && next_g == 4'b0000; c++) begin
                #2;
                if (wd_err) begin
                    pulses++;
                    if (beats_at_pulse < 0) beats_at_pulse = beats;
                end
                if (pulses > 0 && grant != 4'b0000) next_g = grant;
                if (grant == 4'b0001 && s_tvalid && m_tready[0]) beats++;
                @(posedge clk);
                #1;
            end
            check("wd_pulses", 32'(pulses), 32'd1);
            check("wd_beats", 32'(beats_at_pulse), 32'd16);
            check("wd_next_grant", {28'd0, next_g}, {28'd0, 4'b0010});
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- N-to-1 AXI4-Stream arbiter that shares one downstream stream port between NUM_MASTERS upstream masters.
- Feeds the tdest-decoding stream slaves (e.g. the slave that accepts tdest 5'b00010).
- Round-robin arbitration at packet granularity. A grant is held until the tlast beat is accepted, so packets are never interleaved.

Parameters:
- NUM_MASTERS, 4, number of upstream requesters (2..8).
- DATA_W, 8, tdata width.
- DEST_W, 5, tdest width.
- MAX_BEATS, 16, watchdog beat limit per packet (used only with ARB_WATCHDOG_EN).

Ports:
- i_sclk  in  1  clock
- i_srst  in  1  reset, asynchronous, active-high
- i_m_tvalid  in  NUM_MASTERS  per-master tvalid
- i_m_tdata  in  NUM_MASTERS*DATA_W  master k occupies bits [k*DATA_W +: DATA_W]
- i_m_tdest  in  NUM_MASTERS*DEST_W  master k occupies bits [k*DEST_W +: DEST_W]
- i_m_tlast  in  NUM_MASTERS  per-master tlast
- o_m_tready  out  NUM_MASTERS  per-master tready
- o_s_tvalid  out  1  downstream tvalid
- o_s_tdata  out  DATA_W  downstream tdata
- o_s_tdest  out  DEST_W  downstream tdest
- o_s_tlast  out  1  downstream tlast
- i_s_tready  in  1  downstream tready
- o_grant  out  NUM_MASTERS  one-hot current grant, 0 when idle
- o_busy  out  1  high while a packet is locked
- o_wd_err  out  1  one-cycle watchdog pulse (tied 0 without ARB_WATCHDOG_EN)

Behaviour:
- Reset (async, i_srst=1):
  - state=IDLE, grant=0, o_busy=0, o_wd_err=0.
  - Priority pointer last_grant=NUM_MASTERS-1, so master 0 has top priority first.
  - All o_m_tready=0, o_s_tvalid=0, o_s_tdata/tdest/tlast=0.
- State IDLE:
  - Outputs as in reset.
  - If any i_m_tvalid is set, select the first requesting index searching last_grant+1, +2, ... modulo NUM_MASTERS.
  - Register that selection as a one-hot grant and go to LOCKED on the next edge. Arbitration latency is 1 cycle.
  - With no requests, stay in IDLE.
- State LOCKED (granted index g):
  - Combinational datapath: o_s_tvalid=i_m_tvalid[g]; o_s_tdata/tdest/tlast come from slice g; o_m_tready[g]=i_s_tready; all other o_m_tready=0.
  - o_busy=1, o_grant=one-hot g.
  - A beat transfers when o_s_tvalid && i_s_tready.
  - On a transfer with tlast=1: last_grant<=g, grant<=0, go to IDLE. This leaves one bubble cycle between packets.
  - If master g drops tvalid mid-packet, hold the grant (no timeout without the macro).
- Fairness:
  - With all masters continuously requesting single-beat packets, grants rotate 0,1,2,3,0,...
  - Each packet costs 2 cycles: 1 arbitration + 1 beat.
- Requests that change while LOCKED do not affect the current grant.
- Downstream backpressure (i_s_tready=0) holds o_s_* stable as long as the master holds its inputs. The block adds no buffering.
- A reset mid-packet abandons the packet immediately, and the pointer returns to its reset value.
- No combinational path from i_s_tready to o_s_tvalid.

Optional Feature:
- Macro: ARB_WATCHDOG_EN.
- Defined:
  - A beat counter (width clog2(MAX_BEATS)+1) clears on entry to LOCKED and increments on each accepted non-last beat.
  - When the count reaches MAX_BEATS and the current beat is not an accepted tlast, the block:
    - forces a return to IDLE,
    - sets last_grant<=g (the offender loses priority),
    - pulses o_wd_err=1 for one cycle.
  - Remaining beats from that master are re-arbitrated as a new packet.
- Undefined: no counter; o_wd_err is constant 0; a grant is released only by tlast or reset.

Test Plan:
- Reset, then master 2 alone sends a 3-beat packet, data 0xA1,0xA2,0xA3, tdest 5'b00010, i_s_tready=1:
  - o_grant=4'b0100 one cycle after tvalid rises.
  - The three beats appear in consecutive cycles, tlast on 0xA3.
  - IDLE with o_grant=0 the following cycle.
- All 4 masters assert tvalid with 1-beat packets, continuously: grant order 0,1,2,3,0; each master gets exactly 1 beat per 8 cycles.
- Master 1 locked on a 4-beat packet while master 0 requests; i_s_tready toggles 1,0,1,0:
  - No beat from master 0 until master 1's tlast is accepted.
  - o_m_tready[0]=0 throughout; o_s_tdata is stable during the stall cycles.
- Master 3 stops tvalid mid-packet for 5 cycles:
  - The grant stays on master 3 and o_busy=1.
  - The packet completes after tvalid resumes.
- Assert i_srst for 1 cycle during beat 2 of a 4-beat packet from master 1:
  - Asynchronously: all outputs go to 0 and o_grant=0.
  - Master 0 wins the next arbitration if both master 0 and master 1 request.
- ARB_WATCHDOG_EN, MAX_BEATS=16, master 0 sends 20 beats with no tlast:
  - o_wd_err pulses once after 16 accepted beats.
  - With master 1 requesting, master 1 wins the next grant.
